rr_arbiter2: RTL

//  Two-requester round-robin arbiter with a grant-hold handshake.
//  It resolves the requests that the OR/AND request-gating logic merges into one

---
 rtl/rr_arbiter2.sv | 102 ++++++++++
 1 files changed

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin arbiter with grant-hold handshake and watchdog
module rr_arbiter2 #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    input  logic done,
    output logic gnt_a,
    output logic gnt_b,
    output logic busy,
    output logic timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             timeout_q, timeout_d;

    logic owner_req;
    logic wd_expired;
    logic release_now;
    logic pick_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= LAST_B;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
        end
    end

    // A wins when it is the only requester, or on a tie when B was served last.
    assign pick_a      = req_a && (!req_b || (last_q == LAST_B));
    assign owner_req   = (state_q == GNT_A) ? req_a : req_b;
    assign wd_expired  = (cnt_q == CNT_MAX);
    assign release_now = done || !owner_req || wd_expired;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en && (req_a || req_b)) begin
                    if (pick_a) begin
                        state_d = GNT_A;
                        last_d  = LAST_A;
                    end else begin
                        state_d = GNT_B;
                        last_d  = LAST_B;
                    end
                end
            end
            GNT_A, GNT_B: begin
                if (release_now) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    // A done or dropped request takes precedence over the watchdog.
                    timeout_d = wd_expired && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign gnt_a   = (state_q == GNT_A);
    assign gnt_b   = (state_q == GNT_B);
    assign busy    = gnt_a || gnt_b;
    assign timeout = timeout_q;

    a_gnt_exclusive: assert property (@(posedge clk) !(gnt_a && gnt_b));
    a_no_direct_swap: assert property (@(posedge clk) disable iff (rst)
        (gnt_a |=> !gnt_b) and (gnt_b |=> !gnt_a));

endmodule
